layer_act_sequencer: RTL

//  Downstream stage of a neuron layer. Captures the Q1.15 activations of NUM_NEURONS parallel

---
 rtl/layer_act_sequencer_pkg.sv | 20 ++
 rtl/layer_act_sequencer_if.sv | 34 +++
 rtl/layer_act_sequencer_argmax_tracker.sv | 55 +++++
 rtl/layer_act_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/layer_act_sequencer_pkg.sv
// Shared neural-network constants and the sequencer state type.
// Layer sizes here are used to size NUM_NEURONS where a sequencer is instantiated.
package layer_act_sequencer_pkg;

  // Q1.15 activation format
  localparam int          Q15_W    = 16;
  localparam logic [15:0] Q15_MAX  = 16'h7FFF;
  localparam logic [15:0] Q15_ZERO = 16'h0000;

  // Layer sizes of the network
  localparam int L1_NEURONS = 16;
  localparam int L2_NEURONS = 10;

  // COLLECT gathers one activation per neuron; STREAM serialises them
  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_STREAM  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/layer_act_sequencer_if.sv
// Bundle of the neuron-side capture bus, the downstream beat stream and the class result.
// slave is the sequencer's view; master is the view of whatever drives/consumes it.
interface layer_act_sequencer_if #(
  parameter int DATA_W      = 16,
  parameter int NUM_NEURONS = 10
);
  localparam int IDX_W = $clog2(NUM_NEURONS);

  logic [NUM_NEURONS*DATA_W-1:0] act_in;
  logic [NUM_NEURONS-1:0]        act_valid;
  logic                          out_ready;
  logic [DATA_W-1:0]             data_out;
  logic                          data_valid;
  logic [IDX_W-1:0]              data_idx;
  logic                          data_last;
  logic                          busy;
  logic                          class_valid;
  logic [IDX_W-1:0]              class_idx;
  logic [DATA_W-1:0]             class_val;
  logic                          overflow;

  modport slave (
    input  act_in, act_valid, out_ready,
    output data_out, data_valid, data_idx, data_last, busy,
           class_valid, class_idx, class_val, overflow
  );

  modport master (
    output act_in, act_valid, out_ready,
    input  data_out, data_valid, data_idx, data_last, busy,
           class_valid, class_idx, class_val, overflow
  );

endinterface

// File: rtl/layer_act_sequencer_argmax_tracker.sv
// Running argmax over a stream of signed activations.
// best_*_o already include the value presented this cycle, so the owner can
// register the final winner on the same edge that accepts the last beat.
module argmax_tracker #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              update_i,
  input  logic [DATA_W-1:0] val_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [IDX_W-1:0]  best_idx_o,
  output logic [DATA_W-1:0] best_val_o
);

  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [DATA_W-1:0] best_val_q, best_val_d;

  // Merge the presented value into the running best; strict compare keeps the lowest index on ties
  always_comb begin
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    if (clear_i) begin
      best_idx_d = {IDX_W{1'b0}};
      best_val_d = {DATA_W{1'b0}};
    end else if (load_i) begin
      best_idx_d = idx_i;
      best_val_d = val_i;
    end else if (update_i && ($signed(val_i) > $signed(best_val_q))) begin
      best_idx_d = idx_i;
      best_val_d = val_i;
    end else begin
      best_idx_d = best_idx_q;
      best_val_d = best_val_q;
    end
  end

  // Running-best register
  always_ff @(posedge clk) begin
    if (rst) begin
      best_idx_q <= {IDX_W{1'b0}};
      best_val_q <= {DATA_W{1'b0}};
    end else begin
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
    end
  end

  assign best_idx_o = best_idx_d;
  assign best_val_o = best_val_d;

endmodule

// File: rtl/layer_act_sequencer.sv
// Captures one activation per neuron of the producing layer, then streams them
// one per accepted beat to the next layer while tracking the argmax class.
module layer_act_sequencer
  import layer_act_sequencer_pkg::*;
#(
  parameter int DATA_W      = Q15_W,
  parameter int NUM_NEURONS = L2_NEURONS
) (
  input logic                  clk,
  input logic                  rst,
  layer_act_sequencer_if.slave bus
);

  localparam int               IDX_W    = $clog2(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  seq_state_e             state_q, state_d;
  logic [NUM_NEURONS-1:0] mask_q, mask_d;
  logic [DATA_W-1:0]      act_buf_q [NUM_NEURONS];
  logic [DATA_W-1:0]      act_buf_d [NUM_NEURONS];
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   ovf_q, ovf_d;
  logic                   cls_valid_q, cls_valid_d;
  logic [IDX_W-1:0]       cls_idx_q, cls_idx_d;
  logic [DATA_W-1:0]      cls_val_q, cls_val_d;

  logic                   streaming_s;
  logic                   accept_s;
  logic                   is_last_s;
  logic                   start_stream_s;
  logic [DATA_W-1:0]      stream_val_s;
  logic [IDX_W-1:0]       trk_idx_s;
  logic [DATA_W-1:0]      trk_val_s;

  assign streaming_s  = (state_q == ST_STREAM);
  assign is_last_s    = (idx_q == LAST_IDX);
  assign accept_s     = streaming_s & bus.out_ready;
  assign stream_val_s = act_buf_q[idx_q];

  // Next-state, capture buffer, stream index, overflow and class result
  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    act_buf_d      = act_buf_q;
    idx_d          = idx_q;
    ovf_d          = ovf_q;
    cls_valid_d    = 1'b0;
    cls_idx_d      = cls_idx_q;
    cls_val_d      = cls_val_q;
    start_stream_s = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        // Every qualified slice is written; a repeat for the same neuron simply overwrites
        for (int i = 0; i < NUM_NEURONS; i++) begin
          if (bus.act_valid[i]) begin
            act_buf_d[i] = bus.act_in[i*DATA_W +: DATA_W];
            mask_d[i]    = 1'b1;
          end else begin
            act_buf_d[i] = act_buf_q[i];
          end
        end
        if (&mask_d) begin
          state_d        = ST_STREAM;
          idx_d          = {IDX_W{1'b0}};
          start_stream_s = 1'b1;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_STREAM: begin
        // Activations arriving now have nowhere to go: drop them and remember it
        if (|bus.act_valid) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
        if (accept_s && is_last_s) begin
          state_d     = ST_COLLECT;
          mask_d      = {NUM_NEURONS{1'b0}};
          idx_d       = {IDX_W{1'b0}};
          cls_valid_d = 1'b1;
          cls_idx_d   = trk_idx_s;
          cls_val_d   = trk_val_s;
        end else if (accept_s) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        mask_d  = {NUM_NEURONS{1'b0}};
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State, buffer and result registers; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      mask_q      <= {NUM_NEURONS{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      ovf_q       <= 1'b0;
      cls_valid_q <= 1'b0;
      cls_idx_q   <= {IDX_W{1'b0}};
      cls_val_q   <= {DATA_W{1'b0}};
      for (int i = 0; i < NUM_NEURONS; i++) begin
        act_buf_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      idx_q       <= idx_d;
      ovf_q       <= ovf_d;
      cls_valid_q <= cls_valid_d;
      cls_idx_q   <= cls_idx_d;
      cls_val_q   <= cls_val_d;
      act_buf_q   <= act_buf_d;
    end
  end

  argmax_tracker #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (start_stream_s),
    .load_i     (accept_s && (idx_q == {IDX_W{1'b0}})),
    .update_i   (accept_s && (idx_q != {IDX_W{1'b0}})),
    .val_i      (stream_val_s),
    .idx_i      (idx_q),
    .best_idx_o (trk_idx_s),
    .best_val_o (trk_val_s)
  );

  // Stream outputs are decoded straight from registered state so beat 0 appears right after the completing edge
  assign bus.data_valid  = streaming_s;
  assign bus.busy        = streaming_s;
  assign bus.data_out    = streaming_s ? stream_val_s : {DATA_W{1'b0}};
  assign bus.data_idx    = idx_q;
  assign bus.data_last   = streaming_s & is_last_s;
  assign bus.class_valid = cls_valid_q;
  assign bus.class_idx   = cls_idx_q;
  assign bus.class_val   = cls_val_q;
  assign bus.overflow    = ovf_q;

endmodule
